// File: rtl/signal_table_reader.sv
// Read-side master for the SignalTable sample memory: walks addresses 0..data_range-1
// circularly and turns each sample into the duty cycle of one 2^data_width-clock PWM period.
module signal_table_reader #(
  parameter int data_width = 8,
  parameter int addr_width = 7,
  parameter int data_range = 100
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  output logic [addr_width-1:0] address,
  output logic                  WR,
  input  logic [data_width-1:0] dataOut,
  output logic                  pwm_out,
  output logic                  sample_strobe,
  output logic                  table_wrap,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, RUN} state_t;

  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(data_range - 1);
  localparam logic [data_width-1:0] CNT_MAX  = '1;
  localparam logic [data_width-1:0] PREFETCH = data_width'(2);

  state_t                state_q, state_d;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic [data_width-1:0] nxt_q, nxt_d;
  logic [data_width-1:0] duty_q, duty_d;
  logic [data_width-1:0] cnt_q, cnt_d;
  logic                  strobe_q, strobe_d;
  logic                  wrap_q, wrap_d;
  logic [addr_width-1:0] ptr_adv;

  assign ptr_adv = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    nxt_d    = nxt_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        duty_d = '0;
        if (En) state_d = FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // The first sample goes straight to duty; the prefetch path takes over afterwards.
        nxt_d    = dataOut;
        duty_d   = dataOut;
        cnt_d    = '0;
        ptr_d    = ptr_adv;
        strobe_d = 1'b1;
        wrap_d   = (ptr_q == LAST_IDX);
        state_d  = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PREFETCH) nxt_d = dataOut;
        if (cnt_q == CNT_MAX) begin
          if (En) begin
            duty_d   = nxt_q;
            ptr_d    = ptr_adv;
            strobe_d = 1'b1;
            wrap_d   = (ptr_q == LAST_IDX);
          end else begin
            duty_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      nxt_q    <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      nxt_q    <= nxt_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign address       = ptr_q;
  assign WR            = 1'b0;
  assign pwm_out       = (state_q == RUN) && (cnt_q < duty_q);
  assign sample_strobe = strobe_q;
  assign table_wrap    = wrap_q;
  assign busy          = (state_q != IDLE);

endmodule
